// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier.
// Results are registered onto the EX/MEM boundary. While a MUL iterates,
// stallreq_o holds the front end so the MUL operands stay on the inputs.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int ALUSEL_W  = 4,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALUSEL_W-1:0]  alusel,
    input  logic [XLEN-1:0]      s1data,
    input  logic [XLEN-1:0]      s2data,
    input  logic [REGADDR_W-1:0] rd,
    input  logic                 regwe,
    input  logic                 flush_i,
    output logic                 stallreq_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic [REGADDR_W-1:0] rd_o,
    output logic                 regwe_o
);

    localparam int CNT_W   = $clog2(XLEN);
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [ALUSEL_W-1:0] OP_ADD  = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] OP_SUB  = ALUSEL_W'(2);
    localparam logic [ALUSEL_W-1:0] OP_AND  = ALUSEL_W'(3);
    localparam logic [ALUSEL_W-1:0] OP_OR   = ALUSEL_W'(4);
    localparam logic [ALUSEL_W-1:0] OP_XOR  = ALUSEL_W'(5);
    localparam logic [ALUSEL_W-1:0] OP_SLL  = ALUSEL_W'(6);
    localparam logic [ALUSEL_W-1:0] OP_SRL  = ALUSEL_W'(7);
    localparam logic [ALUSEL_W-1:0] OP_SRA  = ALUSEL_W'(8);
    localparam logic [ALUSEL_W-1:0] OP_SLT  = ALUSEL_W'(9);
    localparam logic [ALUSEL_W-1:0] OP_SLTU = ALUSEL_W'(10);
    localparam logic [ALUSEL_W-1:0] OP_MUL  = ALUSEL_W'(11);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_r,      state_nxt_s;
    logic [CNT_W-1:0]       cnt_r,        cnt_nxt_s;
    logic [XLEN-1:0]        mcand_r,      mcand_nxt_s;
    logic [XLEN-1:0]        mplier_r,     mplier_nxt_s;
    logic [XLEN-1:0]        acc_r,        acc_nxt_s;
    logic [REGADDR_W-1:0]   rd_cap_r,     rd_cap_nxt_s;
    logic                   regwe_cap_r,  regwe_cap_nxt_s;
    logic [XLEN-1:0]        wdata_nxt_s;
    logic [REGADDR_W-1:0]   rd_nxt_s;
    logic                   regwe_nxt_s;
    logic                   stall_s;
    logic [XLEN-1:0]        alu_result_s;
    logic                   alu_valid_s;
    logic [XLEN-1:0]        partial_s;
    logic [SHAMT_W-1:0]     shamt_s;

    assign shamt_s = s2data[SHAMT_W-1:0];

    // Single-cycle ALU; alu_valid_s is low for NOP and unused encodings.
    always_comb begin
        alu_result_s = {XLEN{1'b0}};
        alu_valid_s  = 1'b1;
        case (alusel)
            OP_ADD:  alu_result_s = s1data + s2data;
            OP_SUB:  alu_result_s = s1data - s2data;
            OP_AND:  alu_result_s = s1data & s2data;
            OP_OR:   alu_result_s = s1data | s2data;
            OP_XOR:  alu_result_s = s1data ^ s2data;
            OP_SLL:  alu_result_s = s1data << shamt_s;
            OP_SRL:  alu_result_s = s1data >> shamt_s;
            OP_SRA:  alu_result_s = $signed(s1data) >>> shamt_s;
            OP_SLT:  alu_result_s = {{(XLEN-1){1'b0}}, ($signed(s1data) < $signed(s2data))};
            OP_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (s1data < s2data)};
            default: begin
                alu_result_s = {XLEN{1'b0}};
                alu_valid_s  = 1'b0;
            end
        endcase
    end

    // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
    always_comb begin
        if (mplier_r[0]) begin
            partial_s = acc_r + mcand_r;
        end else begin
            partial_s = acc_r;
        end
    end

    // Next-state, datapath and output selection; outputs default to a bubble.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        mcand_nxt_s     = mcand_r;
        mplier_nxt_s    = mplier_r;
        acc_nxt_s       = acc_r;
        rd_cap_nxt_s    = rd_cap_r;
        regwe_cap_nxt_s = regwe_cap_r;
        wdata_nxt_s     = {XLEN{1'b0}};
        rd_nxt_s        = {REGADDR_W{1'b0}};
        regwe_nxt_s     = 1'b0;
        stall_s         = 1'b0;

        if (flush_i) begin
            // Flush wins over everything, including an issuing or completing MUL.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (alusel == OP_MUL) begin
                        stall_s         = 1'b1;
                        state_nxt_s     = ST_BUSY;
                        cnt_nxt_s       = {CNT_W{1'b0}};
                        mcand_nxt_s     = s1data;
                        mplier_nxt_s    = s2data;
                        acc_nxt_s       = {XLEN{1'b0}};
                        rd_cap_nxt_s    = rd;
                        regwe_cap_nxt_s = regwe;
                    end else if (alu_valid_s) begin
                        wdata_nxt_s = alu_result_s;
                        rd_nxt_s    = rd;
                        regwe_nxt_s = regwe;
                    end else begin
                        wdata_nxt_s = {XLEN{1'b0}};
                    end
                end
                ST_BUSY: begin
                    acc_nxt_s    = partial_s;
                    mcand_nxt_s  = mcand_r << 1;
                    mplier_nxt_s = mplier_r >> 1;
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        // Final iteration: release the front end and retire the product.
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        wdata_nxt_s = partial_s;
                        rd_nxt_s    = rd_cap_r;
                        regwe_nxt_s = regwe_cap_r;
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Stall is suppressed while reset is held so the front end is never frozen in reset.
    assign stallreq_o = rst & stall_s;

    // State, multiplier datapath and EX/MEM output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            mcand_r     <= {XLEN{1'b0}};
            mplier_r    <= {XLEN{1'b0}};
            acc_r       <= {XLEN{1'b0}};
            rd_cap_r    <= {REGADDR_W{1'b0}};
            regwe_cap_r <= 1'b0;
            wdata_o     <= {XLEN{1'b0}};
            rd_o        <= {REGADDR_W{1'b0}};
            regwe_o     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mcand_r     <= mcand_nxt_s;
            mplier_r    <= mplier_nxt_s;
            acc_r       <= acc_nxt_s;
            rd_cap_r    <= rd_cap_nxt_s;
            regwe_cap_r <= regwe_cap_nxt_s;
            wdata_o     <= wdata_nxt_s;
            rd_o        <= rd_nxt_s;
            regwe_o     <= regwe_nxt_s;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  alusel;
    logic [31:0] s1data;
    logic [31:0] s2data;
    logic [4:0]  rd;
    logic        regwe;
    logic        flush_i;
    logic        stallreq_o;
    logic [31:0] wdata_o;
    logic [4:0]  rd_o;
    logic        regwe_o;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        bit          is_stall;
        logic        st;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        we;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t mon_e;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] ADD  = 4'd1;
    localparam logic [3:0] SUB  = 4'd2;
    localparam logic [3:0] AND_ = 4'd3;
    localparam logic [3:0] OR_  = 4'd4;
    localparam logic [3:0] XOR_ = 4'd5;
    localparam logic [3:0] SLL  = 4'd6;
    localparam logic [3:0] SRL  = 4'd7;
    localparam logic [3:0] SRA  = 4'd8;
    localparam logic [3:0] SLT  = 4'd9;
    localparam logic [3:0] SLTU = 4'd10;
    localparam logic [3:0] MUL  = 4'd11;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .alusel     (alusel),
        .s1data     (s1data),
        .s2data     (s2data),
        .rd         (rd),
        .regwe      (regwe),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .wdata_o    (wdata_o),
        .rd_o       (rd_o),
        .regwe_o    (regwe_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: cycle n spans posedge n to posedge n+1.
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                chk("sb_late", 64'(mon_e.cyc), 64'(cyc));
            end else if (mon_e.is_stall) begin
                chk("stallreq", 64'(stallreq_o), 64'(mon_e.st));
            end else begin
                chk("out{wdata,rd,regwe}", 64'({wdata_o, rd_o, regwe_o}),
                    64'({mon_e.wd, mon_e.rd, mon_e.we}));
            end
        end
    end

    // Drive one cycle of inputs; expect stall now and the given output next cycle.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic we, input logic fl, input logic est,
                        input logic [31:0] ewd, input logic [4:0] erd, input logic ewe);
        sb_entry_t e;
        @(posedge clk);
        #1;
        alusel  = op;
        s1data  = a;
        s2data  = b;
        rd      = r;
        regwe   = we;
        flush_i = fl;
        e.cyc = cyc; e.is_stall = 1'b1; e.st = est;
        e.wd = 32'd0; e.rd = 5'd0; e.we = 1'b0;
        sb.push_back(e);
        e.cyc = cyc + 1; e.is_stall = 1'b0; e.st = 1'b0;
        e.wd = ewd; e.rd = erd; e.we = ewe;
        sb.push_back(e);
    endtask

    // Full MUL held on the inputs: stall for 32 cycles, result the cycle after.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] prod);
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) step(MUL, a, b, r, 1'b1, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
            else        step(MUL, a, b, r, 1'b1, 1'b0, 1'b0, prod, r, 1'b1);
        end
    endtask

    // Directed stimulus.
    initial begin
        rst = 1'b0; alusel = MUL; s1data = 32'd3; s2data = 32'd4;
        rd = 5'd1; regwe = 1'b1; flush_i = 1'b0;
        #2;
        chk("reset_wdata", 64'(wdata_o), 64'd0);
        chk("reset_rd", 64'(rd_o), 64'd0);
        chk("reset_regwe", 64'(regwe_o), 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd0);
        alusel = NOP;
        @(negedge clk);
        rst = 1'b1;

        step(ADD,  32'hFFFFFFFF, 32'd2, 5'd5, 1'b1, 1'b0, 1'b0, 32'h00000001, 5'd5, 1'b1);
        step(SUB,  32'd3, 32'd5, 5'd6, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 5'd6, 1'b1);
        step(SRA,  32'h80000000, 32'd4, 5'd7, 1'b1, 1'b0, 1'b0, 32'hF8000000, 5'd7, 1'b1);
        step(SLT,  32'hFFFFFFFF, 32'd1, 5'd8, 1'b1, 1'b0, 1'b0, 32'd1, 5'd8, 1'b1);
        step(SLTU, 32'hFFFFFFFF, 32'd1, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0, 5'd8, 1'b1);
        step(AND_, 32'hF0F0F0F0, 32'hFF00FF00, 5'd1, 1'b1, 1'b0, 1'b0, 32'hF000F000, 5'd1, 1'b1);
        step(OR_,  32'hF0F0F0F0, 32'hFF00FF00, 5'd2, 1'b1, 1'b0, 1'b0, 32'hFFF0FFF0, 5'd2, 1'b1);
        step(XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0FF00FF0, 5'd3, 1'b1);
        step(SLL,  32'd1, 32'h00000025, 5'd4, 1'b1, 1'b0, 1'b0, 32'h00000020, 5'd4, 1'b1);
        step(SRL,  32'h80000000, 32'd31, 5'd4, 1'b1, 1'b0, 1'b0, 32'h00000001, 5'd4, 1'b1);
        step(ADD,  32'd10, 32'd20, 5'd0, 1'b1, 1'b0, 1'b0, 32'd30, 5'd0, 1'b1);
        step(ADD,  32'd1, 32'd1, 5'd4, 1'b0, 1'b0, 1'b0, 32'd2, 5'd4, 1'b0);
        step(NOP,  32'd5, 32'd6, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        step(4'd13, 32'd5, 32'd6, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        step(4'd15, 32'd5, 32'd6, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        step(ADD,  32'd1, 32'd1, 5'd9, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);

        // Multiplies, back to back.
        do_mul(32'd7, 32'd6, 5'd3, 32'd42);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000001);
        do_mul(32'h00010000, 32'h00010000, 5'd11, 32'h00000000);

        // Flush in cycle 10 of a MUL abandons it.
        for (int i = 0; i < 10; i++)
            step(MUL, 32'd9, 32'd9, 5'd12, 1'b1, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
        step(MUL, 32'd9, 32'd9, 5'd12, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0);
        step(ADD, 32'd1, 32'd1, 5'd13, 1'b1, 1'b0, 1'b0, 32'd2, 5'd13, 1'b1);
        for (int i = 0; i < 3; i++)
            step(NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);

        // Asynchronous reset between edges, while a MUL is being issued.
        step(ADD, 32'd1, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0, 32'd3, 5'd7, 1'b1);
        step(MUL, 32'd5, 32'd5, 5'd4, 1'b1, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
        #6;
        rst = 1'b0;
        #1;
        chk("midreset_wdata", 64'(wdata_o), 64'd0);
        chk("midreset_rd", 64'(rd_o), 64'd0);
        chk("midreset_regwe", 64'(regwe_o), 64'd0);
        chk("midreset_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        alusel = NOP;
        rst = 1'b1;
        step(ADD, 32'd1, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'd2, 5'd2, 1'b1);
        for (int i = 0; i < 3; i++)
            step(NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs: ALU select, two operands, destination register and write enable.
- Computes the ALU result and registers it into the EX/MEM boundary outputs.
- Single-cycle ops complete with 1-cycle latency.
- MUL runs on an iterative shift-add unit and stalls the front end through `stallreq_o` until the product is ready.

Parameters:
- XLEN, 32, operand/result width.
- ALUSEL_W, 4, width of ALU select.
- REGADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alusel  in  ALUSEL_W  operation from ID/EX.
- s1data  in  XLEN  operand A.
- s2data  in  XLEN  operand B.
- rd  in  REGADDR_W  destination register.
- regwe  in  1  register write enable.
- flush_i  in  1  kill in-flight op and emit a bubble.
- stallreq_o  out  1  request to hold PC/IF/ID/ID-EX.
- wdata_o  out  XLEN  result to EX/MEM.
- rd_o  out  REGADDR_W  destination to EX/MEM.
- regwe_o  out  1  write enable to EX/MEM.

Behaviour:
- alusel encoding:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed), 10 SLTU, 11 MUL.
  - 12-15 are treated as NOP.
- Shift amount is `s2data[4:0]`. SLT/SLTU yield 1 or 0.
- ADD/SUB/MUL wrap modulo 2^XLEN.
- MUL returns the low XLEN bits of the product (identical for signed and unsigned).
- NOP or unused encodings register a bubble: `wdata_o`=0, `rd_o`=0, `regwe_o`=0, regardless of the `regwe`/`rd` inputs.
- Reset (`rst`=0, asynchronous):
  - `wdata_o`=0, `rd_o`=0, `regwe_o`=0.
  - FSM to IDLE; counter, accumulator and operand registers cleared.
  - `stallreq_o`=0 while in reset.
  - Reset mid-MUL abandons the op with no result written.
- FSM states are IDLE and BUSY, with a counter `cnt` of width clog2(XLEN).
- IDLE, non-MUL op: result registered at the next edge (latency 1); `stallreq_o`=0.
- IDLE, MUL:
  - `stallreq_o`=1 combinationally.
  - Next edge captures mcand=`s1data`, mplier=`s2data`, acc=0, `rd`, `regwe`; cnt=0; goes BUSY.
  - Outputs take a bubble at that edge.
- BUSY, each edge:
  - If `mplier[0]`, acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - Inputs are ignored in BUSY.
  - Outputs take a bubble each BUSY edge except the last.
- `stallreq_o` = (IDLE && alusel==MUL) || (BUSY && cnt != XLEN-1).
- BUSY with cnt==XLEN-1:
  - `stallreq_o`=0.
  - Edge performs the final iteration and loads `wdata_o`=final acc, `rd_o`/`regwe_o`=captured values; goes IDLE.
- Timing for XLEN=32: MUL presented in cycle 0 gives `stallreq_o` high in cycles 0..31, low in cycle 32, result visible on outputs in cycle 33.
- Upstream keeps the MUL on the inputs while `stallreq_o`=1 and advances on the edge ending cycle 32. The next instruction is sampled in IDLE in cycle 33.
- Back-to-back MULs: the second MUL enters IDLE in cycle 33 and restarts the sequence with no extra dead cycle.
- `flush_i`=1 at an edge:
  - Outputs take a bubble; FSM to IDLE; cnt=0.
  - Overrides any op, including a MUL just issued or completing.
  - `stallreq_o` is forced 0 in any cycle with `flush_i`=1.
- `regwe`=1 with rd=0 is passed through unchanged; x0 suppression is the register file's responsibility.

Test Plan:
- Reset asserted mid-stream (`rst`=0 asynchronously between edges) -> all outputs 0 immediately, `stallreq_o`=0; after release the next ADD completes normally.
- ADD s1=0xFFFFFFFF s2=2 rd=5 regwe=1 -> next cycle `wdata_o`=0x00000001, `rd_o`=5, `regwe_o`=1. SUB 3-5 -> 0xFFFFFFFE. SRA 0x80000000 by 4 -> 0xF8000000. SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0.
- MUL 7 x 6 rd=3 held while stalled -> `stallreq_o` high exactly cycles 0..31; `regwe_o`=0 through cycle 32; cycle 33 `wdata_o`=42, `rd_o`=3, `regwe_o`=1.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> `wdata_o`=0x00000001. MUL 0x10000 x 0x10000 -> 0x00000000 (wrap).
- `flush_i` pulsed in cycle 10 of a MUL -> bubble output, `stallreq_o` low from cycle 10, no result written; a following ADD 1+1 yields 2 one cycle later.
- NOP with regwe=1 rd=9 -> `regwe_o`=0, `rd_o`=0, `wdata_o`=0. Alusel=13 behaves identically.
